// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC and fills IF/ID one edge after the PC presents an address.
// Stall holds PC and IF/ID; redirect wins over stall; PC past the end of instruction memory parks fetch in HALT.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd100,
    parameter logic [31:0] PC_LIMIT = 32'd16384
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = PC_LIMIT - 32'd4;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        at_end;

    assign pc_plus4 = pc + 32'd4;
    assign target   = redirect_pc & ~32'd3;
    assign at_end   = pc_plus4 > LAST_PC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = (target > LAST_PC) ? HALT : RUN;
        end else if (state == RUN && !stall && at_end) begin
            state_nxt = HALT;
        end
    end

    always_comb begin
        halted = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            // Wrong-path word is squashed; pc4 is don't-care for a bubble and simply holds.
            pc          <= target;
            if_id_instr <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (state == HALT) begin
            if_id_instr <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                if_id_instr <= 32'd0;
                if_id_valid <= 1'b0;
            end
        end else begin
            if_id_instr <= flush ? 32'd0 : instruction;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= ~flush;
            if (!flush) begin
                fetch_count <= fetch_count + 32'd1;
            end
            // The last in-range word is latched but pc parks on it.
            if (!at_end) begin
                pc <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized check of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'd100;
    localparam logic [31:0] PC_LIMIT = 32'd16384;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_halt;

    fetch_stage #(.RESET_PC(RESET_PC), .PC_LIMIT(PC_LIMIT)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd100: return 32'h48080000;
            32'd104: return 32'h48090004;
            32'd108: return 32'h480A0008;
            32'd600: return 32'h2413000F;
            default: return (a * 32'h9E3779B1) ^ 32'h01234567;
        endcase
    endfunction

    assign instruction = mem_word(pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (rst) begin
            m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0; m_count = 0;
        end else if (redirect_valid) begin
            tgt = {redirect_pc[31:2], 2'b00};
            m_pc = tgt; m_instr = 0; m_valid = 0;
            m_halt = (tgt > PC_LIMIT - 4);
        end else if (m_halt) begin
            m_instr = 0; m_valid = 0;
        end else if (stall) begin
            if (flush) begin m_instr = 0; m_valid = 0; end
        end else begin
            m_instr = flush ? 32'd0 : mem_word(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = !flush;
            if (!flush) m_count = m_count + 1;
            if (m_pc + 4 > PC_LIMIT - 4) m_halt = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("fetch_count", fetch_count, m_count);
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rv, input logic [31:0] rp);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0; m_count = 0;
        drive(1, 0, 0, 0, 0);
        step();
        step();
        chk("reset_pc", pc, 32'd100);
        chk("reset_count", fetch_count, 32'd0);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);

        // sequential fetch
        drive(0, 0, 0, 0, 0);
        step();
        chk("seq_pc1", pc, 32'd104);
        chk("seq_instr1", if_id_instr, 32'h48080000);
        chk("seq_pc4_1", if_id_pc4, 32'd104);
        chk("seq_cnt1", fetch_count, 32'd1);
        step();
        chk("seq_pc2", pc, 32'd108);
        chk("seq_instr2", if_id_instr, 32'h48090004);
        chk("seq_cnt2", fetch_count, 32'd2);

        // stall two cycles
        drive(0, 1, 0, 0, 0);
        step();
        step();
        chk("stall_pc", pc, 32'd108);
        chk("stall_instr", if_id_instr, 32'h48090004);
        chk("stall_cnt", fetch_count, 32'd2);
        drive(0, 0, 0, 0, 0);
        step();
        chk("unstall_instr", if_id_instr, 32'h480A0008);
        chk("unstall_pc", pc, 32'd112);

        // redirect with misaligned target
        drive(0, 0, 0, 1, 32'd202);
        step();
        chk("redir_pc", pc, 32'd200);
        chk("redir_bubble", if_id_instr, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        chk("redir_pc4", if_id_pc4, 32'd204);
        chk("redir_instr", if_id_instr, mem_word(32'd200));

        // simultaneous stall, flush, redirect
        drive(0, 1, 1, 1, 32'd300);
        step();
        chk("sim_pc", pc, 32'd300);
        chk("sim_valid", {31'd0, if_id_valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        drive(0, 1, 1, 0, 0);
        step();
        chk("sf_pc", pc, 32'd304);
        chk("sf_instr", if_id_instr, 32'd0);

        // halt at end of memory
        drive(0, 0, 0, 1, 32'd16376);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("end_instr0", if_id_instr, mem_word(32'd16376));
        step();
        chk("end_instr1", if_id_instr, mem_word(32'd16380));
        chk("end_halted", {31'd0, halted}, 32'd1);
        chk("end_pc", pc, 32'd16380);
        drive(0, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("halt_bubble", {31'd0, if_id_valid}, 32'd0);
        chk("halt_pc", pc, 32'd16380);

        // resume and re-halt
        drive(0, 0, 0, 1, 32'd600);
        step();
        chk("resume_halted", {31'd0, halted}, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        chk("resume_instr", if_id_instr, 32'h2413000F);
        drive(0, 0, 0, 1, 32'd16384);
        step();
        chk("oob_halted", {31'd0, halted}, 32'd1);
        drive(0, 0, 0, 0, 0);
        step();

        // reset in HALT
        drive(1, 1, 1, 0, 0);
        step();
        chk("rst_pc", pc, 32'd100);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt", fetch_count, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        chk("rst_resume_pc", pc, 32'd104);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r, s, f, rv;
            logic [31:0] rp;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 4) == 0);
            rv = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: rp = $urandom_range(0, 16383);
                1: rp = PC_LIMIT - 32'($urandom_range(0, 24)) + 32'd4;
                2: rp = $urandom;
                default: rp = PC_LIMIT - 32'($urandom_range(4, 40));
            endcase
            drive(r, s, f, rv, rp);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
